// File: rtl/acq_write_arbiter_pkg.sv
// Shared definitions for the acquisition write path.
// Provides the arbiter state encoding, a width helper and the default
// address/data widths that channel producers also use.
package acq_pkg;

  localparam int unsigned ACQ_AW = 16;
  localparam int unsigned ACQ_DW = 32;

  typedef enum logic {
    IDLE,
    WRITE
  } acq_state_t;

  // Ceiling log2, never less than 1 so that single-value fields still get a bit.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned width;
    width = 1;
    for (int unsigned w = 1; w < 32; w++) begin
      if ((32'd1 << width) < value) width = w + 1;
    end
    return width;
  endfunction

endpackage

// File: rtl/acq_write_arbiter_rr_pick.sv
// Combinational round-robin picker.
// Ports:
//   mask  - request mask, one bit per requester
//   ptr   - index searched first; search continues upward with wrap-around
//   grant - one-hot winner (all zero when mask is empty)
//   idx   - binary index of the winner (0 when mask is empty)
module rr_pick
  import acq_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned PW = clog2(N)
) (
  input  logic [N-1:0]  mask,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] idx
);

  // Walk offsets from farthest to nearest so the nearest hit overwrites.
  always_comb begin
    grant = '0;
    idx   = '0;
    for (int unsigned k = N; k > 0; k--) begin
      if (mask[(32'(ptr) + k - 1) % N]) begin
        grant = '0;
        grant[(32'(ptr) + k - 1) % N] = 1'b1;
        idx = PW'((32'(ptr) + k - 1) % N);
      end
    end
  end

endmodule

// File: rtl/acq_write_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM write master between N_REQ
// acquisition channels.
// Ports:
//   clk_clk, reset_reset         - clock, synchronous active-high reset
//   ch_enable                    - per-channel enable (switch PIO)
//   req_valid/req_addr/req_data  - packed per-channel write requests
//   req_ready                    - one-cycle accept pulse to the granted channel
//   avm_address/avm_write/avm_writedata/avm_waitrequest - Avalon write master
//   busy                         - high while a write is outstanding
//   grant_id                     - last granted channel
//   timeout_err, clear_err       - sticky waitrequest-timeout flag and its clear
module acq_write_arbiter
  import acq_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned AW      = ACQ_AW,
  parameter int unsigned DW      = ACQ_DW,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                    clk_clk,
  input  logic                    reset_reset,
  input  logic [N_REQ-1:0]        ch_enable,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*AW-1:0]     req_addr,
  input  logic [N_REQ*DW-1:0]     req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic [AW-1:0]           avm_address,
  output logic                    avm_write,
  output logic [DW-1:0]           avm_writedata,
  input  logic                    avm_waitrequest,
  output logic                    busy,
  output logic [clog2(N_REQ)-1:0] grant_id,
  output logic                    timeout_err,
  input  logic                    clear_err
);

  localparam int unsigned GW = clog2(N_REQ);
  localparam int unsigned CW = clog2(TIMEOUT + 1);

  acq_state_t      state_q, state_d;
  logic [GW-1:0]   rr_ptr;
  logic [CW-1:0]   wait_cnt;
  logic [N_REQ-1:0] eligible;
  logic [N_REQ-1:0] pick_grant;
  logic [GW-1:0]   pick_idx;
  logic [AW-1:0]   addr_arr [N_REQ];
  logic [DW-1:0]   data_arr [N_REQ];
  logic            write_done;
  logic            write_abort;
  logic [GW-1:0]   next_ptr;

  assign eligible    = req_valid & ch_enable;
  assign write_done  = (state_q == WRITE) && !avm_waitrequest;
  assign write_abort = (state_q == WRITE) && avm_waitrequest && (wait_cnt == CW'(TIMEOUT));
  assign next_ptr    = (grant_id == GW'(N_REQ - 1)) ? '0 : grant_id + GW'(1);

  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      addr_arr[i] = req_addr[i*AW +: AW];
      data_arr[i] = req_data[i*DW +: DW];
    end
  end

  rr_pick #(
    .N  (N_REQ),
    .PW (GW)
  ) u_pick (
    .mask  (eligible),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx)
  );

  // State register
  always_ff @(posedge clk_clk) begin
    if (reset_reset) state_q <= IDLE;
    else             state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|eligible) state_d = WRITE;
      WRITE:   if (write_done || write_abort) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic; ready is held off during reset so nothing is accepted
  // that the datapath will not latch.
  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && !reset_reset) req_ready = pick_grant;
    avm_write = (state_q == WRITE);
    busy      = (state_q == WRITE);
  end

  // Datapath
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      avm_address   <= '0;
      avm_writedata <= '0;
      grant_id      <= '0;
      rr_ptr        <= '0;
      wait_cnt      <= '0;
      timeout_err   <= 1'b0;
    end else begin
      if (clear_err) timeout_err <= 1'b0;
      case (state_q)
        IDLE: begin
          if (|eligible) begin
            avm_address   <= addr_arr[pick_idx];
            avm_writedata <= data_arr[pick_idx];
            grant_id      <= pick_idx;
            wait_cnt      <= '0;
          end
        end
        WRITE: begin
          if (write_done) begin
            rr_ptr <= next_ptr;
          end else if (write_abort) begin
            rr_ptr      <= next_ptr;
            timeout_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_acq_write_arbiter.sv
module tb_acq_write_arbiter;

  logic         clk = 1'b0;
  logic         reset_reset;
  logic [3:0]   ch_enable;
  logic [3:0]   req_valid;
  logic [63:0]  req_addr;
  logic [127:0] req_data;
  logic [3:0]   req_ready;
  logic [15:0]  avm_address;
  logic         avm_write;
  logic [31:0]  avm_writedata;
  logic         avm_waitrequest;
  logic         busy;
  logic [1:0]   grant_id;
  logic         timeout_err;
  logic         clear_err;

  int total = 0;
  int bad   = 0;

  logic [15:0] a_tab [4];
  logic [31:0] d_tab [4];

  always #5 clk = ~clk;

  acq_write_arbiter #(
    .N_REQ   (4),
    .AW      (16),
    .DW      (32),
    .TIMEOUT (5)
  ) dut (
    .clk_clk         (clk),
    .reset_reset     (reset_reset),
    .ch_enable       (ch_enable),
    .req_valid       (req_valid),
    .req_addr        (req_addr),
    .req_data        (req_data),
    .req_ready       (req_ready),
    .avm_address     (avm_address),
    .avm_write       (avm_write),
    .avm_writedata   (avm_writedata),
    .avm_waitrequest (avm_waitrequest),
    .busy            (busy),
    .grant_id        (grant_id),
    .timeout_err     (timeout_err),
    .clear_err       (clear_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_reset     = 1'b1;
    req_valid       = '0;
    ch_enable       = 4'hF;
    avm_waitrequest = 1'b0;
    clear_err       = 1'b0;
    cyc();
    cyc();
    reset_reset = 1'b0;
    #1;
  endtask

  task automatic check_write(input string tag, input int ch);
    check({tag, ".write"}, 64'(avm_write), 64'd1);
    check({tag, ".busy"},  64'(busy), 64'd1);
    check({tag, ".gid"},   64'(grant_id), 64'(ch));
    check({tag, ".addr"},  64'(avm_address), 64'(a_tab[ch]));
    check({tag, ".data"},  64'(avm_writedata), 64'(d_tab[ch]));
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      a_tab[i] = 16'h0100 + 16'(i);
      d_tab[i] = 32'hA000_0000 + 32'(i);
    end
    a_tab[2] = 16'h0010;
    d_tab[2] = 32'hDEAD_BEEF;
    for (int i = 0; i < 4; i++) begin
      req_addr[i*16 +: 16] = a_tab[i];
      req_data[i*32 +: 32] = d_tab[i];
    end

    // Reset state, sampled while reset is still asserted with a request pending
    reset_reset = 1'b1;
    ch_enable = 4'hF; req_valid = 4'hF; avm_waitrequest = 1'b0; clear_err = 1'b0;
    cyc(); cyc();
    check("rst.ready", 64'(req_ready), 64'd0);
    check("rst.write", 64'(avm_write), 64'd0);
    check("rst.busy",  64'(busy), 64'd0);
    check("rst.gid",   64'(grant_id), 64'd0);
    check("rst.addr",  64'(avm_address), 64'd0);
    check("rst.data",  64'(avm_writedata), 64'd0);
    check("rst.err",   64'(timeout_err), 64'd0);

    // Single channel 2, no stall; then rr_ptr must be 3
    do_reset();
    req_valid = 4'b0100;
    #1;
    check("t1.ready", 64'(req_ready), 64'b0100);
    cyc();
    req_valid = '0;
    check_write("t1", 2);
    check("t1.ready_w", 64'(req_ready), 64'd0);
    cyc();
    check("t1.write_off", 64'(avm_write), 64'd0);
    check("t1.busy_off",  64'(busy), 64'd0);
    req_valid = 4'b1001;
    #1;
    check("t1.ptr3", 64'(req_ready), 64'b1000);
    cyc();
    req_valid = '0;
    check_write("t1b", 3);
    cyc();

    // All channels eligible: grants rotate 0,1,2,3,0,1 at one per 2 cycles
    do_reset();
    req_valid = 4'hF;
    for (int i = 0; i < 6; i++) begin
      #1;
      check("t2.ready", 64'(req_ready), 64'(4'b0001 << (i % 4)));
      cyc();
      check_write("t2", i % 4);
      check("t2.ready_w", 64'(req_ready), 64'd0);
      cyc();
      check("t2.idle", 64'(avm_write), 64'd0);
    end
    req_valid = '0;

    // Only channels 1 and 3 enabled
    do_reset();
    ch_enable = 4'b1010;
    req_valid = 4'hF;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("t3.ready", 64'(req_ready), (i % 2 == 0) ? 64'b0010 : 64'b1000);
      cyc();
      check("t3.gid", 64'(grant_id), (i % 2 == 0) ? 64'd1 : 64'd3);
      cyc();
    end
    req_valid = '0;
    ch_enable = 4'hF;

    // waitrequest high for 3 cycles, then low
    do_reset();
    req_valid = 4'b0010;
    avm_waitrequest = 1'b1;
    #1;
    check("t4.ready", 64'(req_ready), 64'b0010);
    cyc();
    req_valid = '0;
    for (int c = 1; c <= 4; c++) begin
      avm_waitrequest = (c < 4);
      #1;
      check_write("t4", 1);
      cyc();
    end
    check("t4.write_off", 64'(avm_write), 64'd0);
    check("t4.busy_off",  64'(busy), 64'd0);
    check("t4.err",       64'(timeout_err), 64'd0);

    // Stuck waitrequest with TIMEOUT=5: 6 write cycles then abort; set beats clear
    do_reset();
    req_valid = 4'b0001;
    avm_waitrequest = 1'b1;
    #1;
    check("t5.ready", 64'(req_ready), 64'b0001);
    cyc();
    req_valid = '0;
    for (int c = 1; c <= 6; c++) begin
      clear_err = (c == 6);
      #1;
      check_write("t5", 0);
      cyc();
    end
    clear_err = 1'b0;
    check("t5.write_off", 64'(avm_write), 64'd0);
    check("t5.busy_off",  64'(busy), 64'd0);
    check("t5.err_set",   64'(timeout_err), 64'd1);
    avm_waitrequest = 1'b0;
    req_valid = 4'b0011;
    #1;
    check("t5.next", 64'(req_ready), 64'b0010);
    cyc();
    req_valid = '0;
    check("t5.err_hold", 64'(timeout_err), 64'd1);
    clear_err = 1'b1;
    cyc();
    clear_err = 1'b0;
    check("t5.err_clr", 64'(timeout_err), 64'd0);

    // Reset on the 2nd WRITE cycle after rr_ptr has moved to 3
    do_reset();
    req_valid = 4'b0100;
    cyc();
    req_valid = '0;
    cyc();
    req_valid = 4'hF;
    avm_waitrequest = 1'b1;
    #1;
    check("t6.ready", 64'(req_ready), 64'b1000);
    cyc();
    cyc();
    check_write("t6", 3);
    reset_reset = 1'b1;
    cyc();
    check("t6.write", 64'(avm_write), 64'd0);
    check("t6.busy",  64'(busy), 64'd0);
    check("t6.gid",   64'(grant_id), 64'd0);
    reset_reset = 1'b0;
    avm_waitrequest = 1'b0;
    #1;
    check("t6.restart", 64'(req_ready), 64'b0001);
    cyc();
    req_valid = '0;
    check_write("t6b", 0);
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/acq_write_arbiter.md
Name: acq_write_arbiter

Overview:
- Round-robin arbiter that shares one Avalon-MM write master into the HPS between N_REQ acquisition channels.
- Each channel presents single-word writes (address + data) on a valid/ready handshake.
- The arbiter grants one channel at a time, drives the Avalon write until waitrequest drops, and aborts on timeout.
- Per-channel enables come from the 4-bit switch PIO export, so a channel can be muted at run time.

Parameters:
- N_REQ, 4, number of requesting channels (2..8).
- AW, 16, Avalon word address width.
- DW, 32, write data width.
- TIMEOUT, 255, max cycles avm_waitrequest may stay high before abort (1..65535).

Ports:
- clk_clk  in  1  system clock.
- reset_reset  in  1  synchronous, active-high reset.
- ch_enable  in  N_REQ  per-channel enable (switch PIO); 0 = channel ignored.
- req_valid  in  N_REQ  channel i has a write pending.
- req_addr  in  N_REQ*AW  packed addresses; channel i at [i*AW +: AW].
- req_data  in  N_REQ*DW  packed data; channel i at [i*DW +: DW].
- req_ready  out  N_REQ  one-cycle accept pulse to the granted channel.
- avm_address  out  AW  Avalon address.
- avm_write  out  1  Avalon write strobe.
- avm_writedata  out  DW  Avalon write data.
- avm_waitrequest  in  1  slave stall.
- busy  out  1  high while in WRITE state.
- grant_id  out  clog2(N_REQ)  last granted channel.
- timeout_err  out  1  sticky abort flag.
- clear_err  in  1  clears timeout_err.

Behaviour:
- Reset values: req_ready=0, avm_write=0, avm_address=0, avm_writedata=0, busy=0, grant_id=0, timeout_err=0, state=IDLE, rr_ptr=0, wait counter=0.
- Eligible set = req_valid & ch_enable, sampled only in IDLE.
- State IDLE:
  - If the eligible set is non-zero, pick the first eligible index searching upward from rr_ptr with wrap-around (rr_ptr, rr_ptr+1, ..., N_REQ-1, 0, ...).
  - In that same cycle, drive req_ready[g]=1 (combinational from registered state + inputs; exactly one bit high).
  - On the next edge, latch addr/data of g into avm_address/avm_writedata, set avm_write=1, busy=1, grant_id=g, wait counter=0, go to WRITE.
  - If the eligible set is empty, stay in IDLE with all req_ready=0.
- State WRITE:
  - avm_write, avm_address and avm_writedata are held stable.
  - If avm_waitrequest=0 on an edge: the transfer completes; next cycle avm_write=0, busy=0, rr_ptr=(g+1) mod N_REQ, go to IDLE.
  - Else increment the wait counter. When the counter reaches TIMEOUT (write asserted for TIMEOUT+1 cycles without acceptance): drop avm_write, set timeout_err=1, rr_ptr=(g+1) mod N_REQ, go to IDLE. The aborted word is lost and not retried.
- Minimum throughput: one write per 2 cycles (IDLE grant cycle + one WRITE cycle with waitrequest=0).
- Requester contract:
  - Hold valid/addr/data stable until req_ready.
  - Valid may drop without ready; the arbiter then simply does not select that channel.
  - A channel deasserting ch_enable while in WRITE does not affect the in-flight write.
- timeout_err:
  - Set has priority over clear_err in the same cycle.
  - Otherwise clear_err=1 clears it on the next edge.
- Reset asserted mid-WRITE: avm_write=0 on the following edge and all state is reset. No partial completion is signalled.
- Fairness: with all N_REQ channels continuously eligible, grants rotate 0,1,...,N_REQ-1,0,...; no channel waits more than N_REQ-1 grants.
- Widths: grant_id is clog2(N_REQ), minimum 1 bit. The wait counter is clog2(TIMEOUT+1) bits and never wraps.

Decomposition:
- Package acq_pkg:
  - state enum (IDLE, WRITE);
  - function clog2;
  - default AW/DW constants shared with channel producers.
- Sub-module rr_pick: combinational N_REQ-wide round-robin priority picker. Inputs are the eligible mask and rr_ptr; outputs are a one-hot grant and the grant index. It is reused by a future read-side arbiter.

Test Plan:
- Single channel 2 valid (addr 0x0010, data 0xDEADBEEF), waitrequest=0: req_ready[2] pulses 1 cycle; next cycle avm_write=1 with addr 0x0010 and data 0xDEADBEEF for exactly 1 cycle; grant_id=2; then rr_ptr=3.
- All 4 channels valid and enabled continuously, waitrequest=0: grant sequence 0,1,2,3,0,1; one write every 2 cycles; no duplicate req_ready bits.
- ch_enable=4'b1010 with all valid: only channels 1 and 3 are granted, alternating. Channels 0 and 2 never see req_ready.
- waitrequest high for 3 cycles, then low: avm_write stays high 4 cycles with stable addr/data, completes once, timeout_err stays 0.
- TIMEOUT=5, waitrequest stuck high: avm_write high 6 cycles then drops, timeout_err=1, next grant goes to the following channel. clear_err pulse returns timeout_err to 0.
- reset_reset asserted on the 2nd WRITE cycle: next edge avm_write=0, busy=0, grant_id=0. After release, arbitration restarts at channel 0.
